// File: rtl/frog_cmd_scheduler_if.sv
// Keyboard/frog-status inputs and frog command outputs of the frog command scheduler.
// The master side drives keycode, frame sync and frog status; the slave side is the scheduler.
interface frog_cmd_scheduler_if;
  logic        frame_clk;
  logic [15:0] keycode;
  logic [2:0]  frog_dead;
  logic [2:0]  frog_sel;
  logic        move_up;
  logic        move_down;
  logic        move_left;
  logic        move_right;
  logic        cmd_busy;

  modport master (
    output frame_clk, keycode, frog_dead,
    input  frog_sel, move_up, move_down, move_left, move_right, cmd_busy
  );

  modport slave (
    input  frame_clk, keycode, frog_dead,
    output frog_sel, move_up, move_down, move_left, move_right, cmd_busy
  );
endinterface

// File: rtl/frog_cmd_scheduler.sv
// Turns raw USB keycodes into frame-aligned move pulses for the active frog and keeps the
// active-frog selection pointed at a living frog.
module frog_cmd_scheduler #(
  parameter int unsigned REPEAT_FRAMES = 8,
  parameter int unsigned CNT_W         = 6
) (
  input logic                  Clk,
  input logic                  Reset,
  frog_cmd_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWaitFrame, StPulse, StHold} state_e;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;

  localparam logic [15:0] KeyL    = 16'h0050;
  localparam logic [15:0] KeyR    = 16'h004F;
  localparam logic [15:0] KeyU    = 16'h0052;
  localparam logic [15:0] KeyD    = 16'h0051;
  localparam logic [15:0] KeySel1 = 16'h0059;
  localparam logic [15:0] KeySel2 = 16'h005A;
  localparam logic [15:0] KeySel3 = 16'h005B;

  localparam bit RepeatEn = (REPEAT_FRAMES != 0);
  localparam logic [CNT_W-1:0] RepLast = CNT_W'((REPEAT_FRAMES == 0) ? 0 : REPEAT_FRAMES - 1);

  state_e           state_q;
  dir_e             dir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       move_q;  // {up, down, left, right}
  logic             busy_q;
  logic [2:0]       sel_q;
  logic             sync1_q, sync2_q;

  logic       tick;
  logic       key_dir, key_sel, key_none, key_held;
  dir_e       key_dir_code;
  logic [2:0] sel_tgt, sel_adv, alive;
  logic       sel_dead;

  function automatic logic [15:0] dir_code(dir_e d);
    dir_code = KeyU;
    case (d)
      DirDown:  dir_code = KeyD;
      DirLeft:  dir_code = KeyL;
      DirRight: dir_code = KeyR;
      default:  ;
    endcase
  endfunction

  function automatic logic [3:0] dir_onehot(dir_e d);
    dir_onehot = 4'b1000;
    case (d)
      DirDown:  dir_onehot = 4'b0100;
      DirLeft:  dir_onehot = 4'b0010;
      DirRight: dir_onehot = 4'b0001;
      default:  ;
    endcase
  endfunction

  assign tick     = sync1_q & ~sync2_q;
  assign alive    = ~bus.frog_dead;
  assign sel_dead = |(sel_q & bus.frog_dead);
  assign key_none = ~key_dir & ~key_sel;
  assign key_held = (bus.keycode == dir_code(dir_q));

  always_comb begin
    key_dir      = 1'b0;
    key_sel      = 1'b0;
    key_dir_code = DirUp;
    sel_tgt      = 3'b000;
    case (bus.keycode)
      KeyU:    begin key_dir = 1'b1; key_dir_code = DirUp;    end
      KeyD:    begin key_dir = 1'b1; key_dir_code = DirDown;  end
      KeyL:    begin key_dir = 1'b1; key_dir_code = DirLeft;  end
      KeyR:    begin key_dir = 1'b1; key_dir_code = DirRight; end
      KeySel1: begin key_sel = 1'b1; sel_tgt = 3'b001;        end
      KeySel2: begin key_sel = 1'b1; sel_tgt = 3'b010;        end
      KeySel3: begin key_sel = 1'b1; sel_tgt = 3'b100;        end
      default: ;
    endcase
  end

  // Next living frog in cyclic order 1->2->3->1; with nothing selected, the lowest living one.
  always_comb begin
    sel_adv = 3'b000;
    case (sel_q)
      3'b001:  sel_adv = alive[1] ? 3'b010 : alive[2] ? 3'b100 : alive[0] ? 3'b001 : 3'b000;
      3'b010:  sel_adv = alive[2] ? 3'b100 : alive[0] ? 3'b001 : alive[1] ? 3'b010 : 3'b000;
      3'b100:  sel_adv = alive[0] ? 3'b001 : alive[1] ? 3'b010 : alive[2] ? 3'b100 : 3'b000;
      default: sel_adv = alive[0] ? 3'b001 : alive[1] ? 3'b010 : alive[2] ? 3'b100 : 3'b000;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= StIdle;
      dir_q   <= DirUp;
      cnt_q   <= '0;
      move_q  <= 4'b0000;
      busy_q  <= 1'b0;
      sel_q   <= 3'b001;
    end else begin
      sync1_q <= bus.frame_clk;
      sync2_q <= sync1_q;

      if (state_q == StIdle && key_sel && |(sel_tgt & alive)) begin
        sel_q <= sel_tgt;
      end else if (tick && (sel_q == 3'b000 || sel_dead)) begin
        sel_q <= sel_adv;
      end

      case (state_q)
        StIdle: begin
          if (key_dir && sel_q != 3'b000) begin
            state_q <= StWaitFrame;
            dir_q   <= key_dir_code;
            busy_q  <= 1'b1;
          end
        end
        StWaitFrame: begin
          if (key_none) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (tick) begin
            state_q <= StPulse;
            move_q  <= dir_onehot(dir_q);
          end
        end
        StPulse: begin
          if (sel_dead || tick) begin
            state_q <= StHold;
            move_q  <= 4'b0000;
            cnt_q   <= '0;
          end
        end
        StHold: begin
          if (!key_held) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (RepeatEn && tick) begin
            if (cnt_q == RepLast) begin
              cnt_q <= '0;
              if (sel_q != 3'b000) begin
                state_q <= StPulse;
                move_q  <= dir_onehot(dir_q);
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          move_q  <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.frog_sel   = sel_q;
  assign bus.move_up    = move_q[3];
  assign bus.move_down  = move_q[2];
  assign bus.move_left  = move_q[1];
  assign bus.move_right = move_q[0];
  assign bus.cmd_busy   = busy_q;

endmodule

// File: tb/tb_frog_cmd_scheduler.sv
// Directed bench for frog_cmd_scheduler: frame pulses, auto-repeat spacing, selection,
// dead-frog handling and asynchronous reset.
module tb_frog_cmd_scheduler;

  logic Clk;
  logic Reset;
  logic mon_clr;
  int   tests;
  int   failed;
  int   lat;

  frog_cmd_scheduler_if bus ();

  frog_cmd_scheduler #(
    .REPEAT_FRAMES(8),
    .CNT_W        (6)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pulse monitor: counts rising edges per move output and records frames of move_left starts.
  logic [3:0] mv;
  logic [3:0] prev_mv;
  logic       fc_prev;
  int         frame_no, up_starts, down_starts, left_starts, right_starts, up_run, up_width;
  int         left_frame [8];

  assign mv = {bus.move_up, bus.move_down, bus.move_left, bus.move_right};

  always @(posedge Clk) begin
    prev_mv <= mv;
    fc_prev <= bus.frame_clk;
    if (mon_clr) begin
      frame_no     <= 0;
      up_starts    <= 0;
      down_starts  <= 0;
      left_starts  <= 0;
      right_starts <= 0;
      up_run       <= 0;
      up_width     <= 0;
      for (int i = 0; i < 8; i++) left_frame[i] <= 0;
    end else begin
      if (bus.frame_clk && !fc_prev) frame_no <= frame_no + 1;
      if (mv[3] && !prev_mv[3]) up_starts <= up_starts + 1;
      if (mv[2] && !prev_mv[2]) down_starts <= down_starts + 1;
      if (mv[0] && !prev_mv[0]) right_starts <= right_starts + 1;
      if (mv[1] && !prev_mv[1]) begin
        left_starts <= left_starts + 1;
        if (left_starts < 8) left_frame[left_starts] <= frame_no;
      end
      if (mv[3]) begin
        up_run <= up_run + 1;
      end else begin
        up_run <= 0;
        if (prev_mv[3]) up_width <= up_run;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame of 20 Clk; entered and left on a negedge.
  task automatic frame();
    bus.frame_clk = 1'b1;
    repeat (10) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
  endtask

  task automatic clear_monitor();
    mon_clr = 1'b1;
    @(negedge Clk);
    mon_clr = 1'b0;
  endtask

  initial begin
    tests         = 0;
    failed        = 0;
    Reset         = 1'b1;
    mon_clr       = 1'b1;
    bus.frame_clk = 1'b0;
    bus.keycode   = 16'h0000;
    bus.frog_dead = 3'b000;
    repeat (2) @(negedge Clk);
    check("reset_sel", 32'(bus.frog_sel), 32'h1);
    check("reset_moves", 32'(mv), 32'h0);
    check("reset_busy", 32'(bus.cmd_busy), 32'h0);
    Reset = 1'b0;
    @(negedge Clk);
    mon_clr = 1'b0;

    // Single up press held for one frame.
    bus.keycode = 16'h0052;
    @(posedge Clk); #1;
    check("t1_arm_busy", 32'(bus.cmd_busy), 32'h1);
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    lat = 0;
    while (bus.move_up !== 1'b1 && lat < 6) begin
      @(posedge Clk); #1;
      lat++;
    end
    check("t1_pulse_latency", 32'(lat), 32'd2);
    @(negedge Clk);
    repeat (8) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
    check("t1_pulse_held", 32'(bus.move_up), 32'h1);
    bus.keycode = 16'h0000;
    frame();
    check("t1_up_starts", 32'(up_starts), 32'd1);
    check("t1_up_width", 32'(up_width), 32'd20);
    check("t1_other_starts", 32'(down_starts + left_starts + right_starts), 32'd0);
    check("t1_idle", 32'(bus.cmd_busy), 32'h0);

    // Release before the tick: no pulse.
    bus.keycode = 16'h0051;
    @(posedge Clk); #1;
    check("t1b_arm", 32'(bus.cmd_busy), 32'h1);
    @(negedge Clk);
    bus.keycode = 16'h0000;
    @(posedge Clk); #1;
    check("t1b_abort", 32'(bus.cmd_busy), 32'h0);
    @(negedge Clk);
    frame();
    check("t1b_no_down", 32'(down_starts), 32'd0);

    // Auto-repeat: hold left for 30 frames.
    clear_monitor();
    bus.keycode = 16'h0050;
    repeat (30) frame();
    bus.keycode = 16'h0000;
    frame();
    check("t2_left_count", 32'(left_starts), 32'd4);
    check("t2_frame_a", 32'(left_frame[0]), 32'd1);
    check("t2_frame_b", 32'(left_frame[1]), 32'd10);
    check("t2_frame_c", 32'(left_frame[2]), 32'd19);
    check("t2_frame_d", 32'(left_frame[3]), 32'd28);
    check("t2_idle", 32'(bus.cmd_busy), 32'h0);

    // Select keys against dead frogs.
    bus.frog_dead = 3'b010;
    bus.keycode   = 16'h005A;
    @(posedge Clk); #1;
    check("t3_sel_dead_ignored", 32'(bus.frog_sel), 32'h1);
    @(negedge Clk);
    bus.keycode = 16'h005B;
    @(posedge Clk); #1;
    check("t3_sel3", 32'(bus.frog_sel), 32'h4);
    @(negedge Clk);
    bus.keycode = 16'h0059;
    @(posedge Clk); #1;
    check("t4_sel1", 32'(bus.frog_sel), 32'h1);
    @(negedge Clk);
    bus.keycode = 16'h0000;

    // Dead-frog advance and all-dead.
    bus.frog_dead = 3'b011;
    frame();
    check("t4_advance", 32'(bus.frog_sel), 32'h4);
    bus.frog_dead = 3'b111;
    frame();
    check("t4_none_alive", 32'(bus.frog_sel), 32'h0);
    clear_monitor();
    bus.keycode = 16'h0052;
    @(posedge Clk); #1;
    check("t4_no_arm", 32'(bus.cmd_busy), 32'h0);
    @(negedge Clk);
    frame();
    frame();
    check("t4_no_pulse", 32'(up_starts), 32'd0);
    bus.keycode   = 16'h0000;
    bus.frog_dead = 3'b100;
    frame();
    check("t4_reselect", 32'(bus.frog_sel), 32'h1);
    bus.frog_dead = 3'b000;
    @(negedge Clk);

    // Selected frog dies mid-pulse.
    clear_monitor();
    bus.keycode = 16'h004F;
    frame();
    check("t5_pulse", 32'(bus.move_right), 32'h1);
    bus.frog_dead = 3'b001;
    @(posedge Clk); #1;
    check("t5_drop", 32'(bus.move_right), 32'h0);
    check("t5_busy_hold", 32'(bus.cmd_busy), 32'h1);
    @(negedge Clk);
    frame();
    check("t5_no_repulse", 32'(right_starts), 32'd1);
    check("t5_sel_adv", 32'(bus.frog_sel), 32'h2);
    bus.keycode = 16'h0000;
    repeat (2) @(negedge Clk);
    check("t5_idle", 32'(bus.cmd_busy), 32'h0);
    bus.frog_dead = 3'b000;

    // Asynchronous reset mid-pulse.
    bus.keycode = 16'h0052;
    frame();
    check("t6_pulse", 32'(bus.move_up), 32'h1);
    Reset = 1'b1;
    #1;
    check("t6_rst_move", 32'(mv), 32'h0);
    check("t6_rst_sel", 32'(bus.frog_sel), 32'h1);
    check("t6_rst_busy", 32'(bus.cmd_busy), 32'h0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("t6_rearm", 32'(bus.cmd_busy), 32'h1);
    check("t6_no_move_yet", 32'(bus.move_up), 32'h0);
    @(negedge Clk);
    frame();
    check("t6_new_pulse", 32'(bus.move_up), 32'h1);
    bus.keycode = 16'h0000;
    frame();
    frame();
    check("t6_final_idle", 32'(bus.cmd_busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
